// File: rtl/sd_otf_converter.sv
// sd_otf_converter
//
// Receiving end of the online adder-tree datapath. Consumes an MSD-first
// radix-2 signed-digit stream encoded as a (p, n) rail pair. It converts
// the stream on the fly into an (N+1)-bit two's-complement word, using the
// Q/QM scheme, so no final carry-propagate add is needed.
//
// The first DELAY valid digits after start are the upstream tree's online
// delay and are discarded. Input stalls are tolerated: only cycles with
// in_valid=1 advance the conversion. The result is held under a
// valid/ready handshake.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start         one-cycle pulse, begins a conversion (honoured only in idle)
//   in_valid      z_p/z_n carry a digit this cycle
//   z_p, z_n      positive / negative rail of the signed digit
//   out_ready     downstream accepts the result
//   busy          high from start acceptance until the result is accepted
//   result        N+1 bit two's-complement value of sum d_j*2^(N-j)
//   result_valid  result is stable and valid
//   err           sticky: an illegal (1,1) digit was seen in this conversion

module sd_otf_converter #(
  parameter int unsigned N     = 16,
  parameter int unsigned DELAY = 2,
  localparam int unsigned CW   = $clog2(N + DELAY + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic         z_p,
  input  logic         z_n,
  input  logic         out_ready,
  output logic         busy,
  output logic [N:0]   result,
  output logic         result_valid,
  output logic         err
);

  typedef enum logic [1:0] {
    StIdle,
    StSkip,
    StConv,
    StDone
  } state_e;

  state_e        state_q;
  logic [N:0]    q_q;
  logic [N:0]    qm_q;
  logic [CW-1:0] count_q;
  logic [N:0]    result_q;
  logic          result_valid_q;
  logic          busy_q;
  logic          err_q;

  // Digit decode. (1,1) is illegal: it is treated as zero and flags err.
  logic dig_pos;
  logic dig_neg;
  logic dig_bad;

  always_comb begin
    dig_pos = z_p & ~z_n;
    dig_neg = z_n & ~z_p;
    dig_bad = z_p & z_n;
  end

  // On-the-fly conversion step. Q holds the exact prefix value. QM holds
  // Q minus one ulp. Selecting the right source avoids any borrow
  // propagation when a -1 digit arrives.
  logic [N:0] q_nxt;
  logic [N:0] qm_nxt;

  always_comb begin
    q_nxt  = {q_q[N-1:0], 1'b0};
    qm_nxt = {qm_q[N-1:0], 1'b1};
    if (dig_pos) begin
      q_nxt  = {q_q[N-1:0], 1'b1};
      qm_nxt = {q_q[N-1:0], 1'b0};
    end else if (dig_neg) begin
      q_nxt  = {qm_q[N-1:0], 1'b1};
      qm_nxt = {qm_q[N-1:0], 1'b0};
    end
  end

  logic [CW-1:0] count_inc;

  always_comb begin
    count_inc = count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      q_q            <= '0;
      qm_q           <= '1;
      count_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // The digit present alongside start is deliberately ignored.
          if (start) begin
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            q_q     <= '0;
            qm_q    <= '1;
            count_q <= '0;
            state_q <= (DELAY == 0) ? StConv : StSkip;
          end
        end

        StSkip: begin
          if (in_valid) begin
            err_q <= err_q | dig_bad;
            if (count_inc == CW'(DELAY)) begin
              count_q <= '0;
              state_q <= StConv;
            end else begin
              count_q <= count_inc;
            end
          end
        end

        StConv: begin
          if (in_valid) begin
            q_q     <= q_nxt;
            qm_q    <= qm_nxt;
            count_q <= count_inc;
            err_q   <= err_q | dig_bad;
            // Capture the final value directly so result appears one clock
            // after the last digit is sampled.
            if (count_inc == CW'(N)) begin
              result_q       <= q_nxt;
              result_valid_q <= 1'b1;
              state_q        <= StDone;
            end
          end
        end

        StDone: begin
          if (out_ready) begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sd_otf_converter.sv
module tb_sd_otf_converter;

  localparam int W = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   start;
  logic         in_valid;
  logic         z_p;
  logic         z_n;
  logic         out_ready;

  logic         busy0, rv0, err0;
  logic [W-1:0] res0;
  logic         busy1, rv1, err1;
  logic [W-1:0] res1;

  // sel 0: no online delay, sel 1: two discarded leading digits
  sd_otf_converter #(.N(16), .DELAY(0)) u_d0 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .z_p(z_p), .z_n(z_n),
    .out_ready(out_ready), .busy(busy0), .result(res0), .result_valid(rv0), .err(err0)
  );

  sd_otf_converter #(.N(16), .DELAY(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .z_p(z_p), .z_n(z_n),
    .out_ready(out_ready), .busy(busy1), .result(res1), .result_valid(rv1), .err(err1)
  );

  typedef struct {
    int          sel;
    logic [31:0] p_bits;   // bit i = p rail of the i-th digit sent (0 first)
    logic [31:0] n_bits;
    int          ndig;
    bit          stall;    // in_valid alternates 1/0 starting with 1
    logic [W-1:0] exp_res;
    bit          exp_err;
    int          exp_lat;  // cycle index (start cycle = 0) where result_valid first rises
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] res_of(input int sel);
    return (sel == 0) ? res0 : res1;
  endfunction
  function automatic logic rv_of(input int sel);
    return (sel == 0) ? rv0 : rv1;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction
  function automatic logic err_of(input int sel);
    return (sel == 0) ? err0 : err1;
  endfunction

  // Runs one conversion. With hold_ready=1 it returns while the DUT sits in
  // DONE with out_ready low.
  task automatic run_vec(input vec_t v, input int id, input bit hold_ready);
    int cyc;
    int i;
    int got;
    @(negedge clk);
    start[v.sel] = 1'b1;
    in_valid     = 1'b1;   // digit in the start cycle must be ignored
    z_p          = 1'b1;
    z_n          = 1'b0;
    out_ready    = !hold_ready;
    @(posedge clk);
    #1;
    check($sformatf("v%0d.busy_start", id), 32'(busy_of(v.sel)), 32'd1);
    check($sformatf("v%0d.err_start", id), 32'(err_of(v.sel)), 32'd0);
    @(negedge clk);
    start = '0;
    cyc = 1;
    i   = 0;
    got = -1;
    while (got < 0 && cyc < 200) begin
      if (i < v.ndig && !(v.stall && (cyc % 2 == 0))) begin
        in_valid = 1'b1;
        z_p      = v.p_bits[i];
        z_n      = v.n_bits[i];
        i++;
      end else begin
        in_valid = 1'b0;
        z_p      = 1'b1;   // junk on stalled cycles must not be consumed
        z_n      = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rv_of(v.sel)) got = cyc;
      @(negedge clk);
    end
    check($sformatf("v%0d.latency", id), 32'(got), 32'(v.exp_lat));
    check($sformatf("v%0d.result", id), 32'(res_of(v.sel)), 32'(v.exp_res));
    check($sformatf("v%0d.err", id), 32'(err_of(v.sel)), 32'(v.exp_err));
    if (!hold_ready) begin
      // Handshake completes on this edge; a digit arriving in DONE is dropped.
      in_valid = 1'b1;
      z_p      = 1'b1;
      z_n      = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.rv_after", id), 32'(rv_of(v.sel)), 32'd0);
      check($sformatf("v%0d.busy_after", id), 32'(busy_of(v.sel)), 32'd0);
      check($sformatf("v%0d.res_hold", id), 32'(res_of(v.sel)), 32'(v.exp_res));
      @(negedge clk);
      in_valid = 1'b0;
      z_p      = 1'b0;
    end
  endtask

  vec_t vecs [10];

  initial begin
    //            sel p_bits         n_bits        nd  st  exp_res     err lat
    vecs[0] = '{0, 32'h0000_FFFF, 32'h0000_0000, 16, 0, 17'h0FFFF, 0, 17};
    vecs[1] = '{0, 32'h0000_0000, 32'h0000_FFFF, 16, 0, 17'h10001, 0, 17};
    vecs[2] = '{0, 32'h0000_0001, 32'h0000_0002, 16, 0, 17'h04000, 0, 17};
    vecs[3] = '{1, 32'h0000_0004, 32'h0000_0003, 18, 0, 17'h08000, 0, 19};
    vecs[4] = '{0, 32'h0000_0001, 32'h0000_0002, 16, 1, 17'h04000, 0, 32};
    vecs[5] = '{1, 32'h0000_0004, 32'h0000_0003, 18, 1, 17'h08000, 0, 36};
    vecs[6] = '{0, 32'h0000_0020, 32'h0000_0020, 16, 0, 17'h00000, 1, 17};
    vecs[7] = '{0, 32'h0000_8000, 32'h0000_0001, 16, 0, 17'h18001, 0, 17};
    vecs[8] = '{0, 32'h0000_0000, 32'h0000_8000, 16, 0, 17'h1FFFF, 0, 17};
    vecs[9] = '{1, 32'h0000_0000, 32'h0000_0000, 18, 0, 17'h00000, 0, 19};

    rst       = 1'b0;
    start     = '0;
    in_valid  = 1'b0;
    z_p       = 1'b0;
    z_n       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'({busy1, busy0}), 32'd0);
    check("reset.rv", 32'({rv1, rv0}), 32'd0);
    check("reset.err", 32'({err1, err0}), 32'd0);
    check("reset.res", 32'({res1, res0}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // vecs[7] follows the illegal-code run, so its err_start check covers err clearing.
    for (int k = 0; k < 10; k++) run_vec(vecs[k], k, 1'b0);

    // Backpressure: hold out_ready low, pulse start in DONE.
    run_vec(vecs[1], 10, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start[0] = (k == 2);
      in_valid = 1'b1;
      z_p      = 1'b1;
      z_n      = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d.rv", k), 32'(rv0), 32'd1);
      check($sformatf("bp%0d.res", k), 32'(res0), 32'(17'h10001));
      check($sformatf("bp%0d.busy", k), 32'(busy0), 32'd1);
    end
    @(negedge clk);
    start     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.rv_after", 32'(rv0), 32'd0);
    check("bp.busy_after", 32'(busy0), 32'd0);
    check("bp.res_hold", 32'(res0), 32'(17'h10001));
    @(posedge clk);
    #1;
    check("bp.still_idle", 32'(busy0), 32'd0);

    // Abort by reset after 8 digits, one of them illegal.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      z_p      = 1'b1;
      z_n      = (k == 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    z_p      = 1'b0;
    z_n      = 1'b0;
    check("abort.err_before", 32'(err0), 32'd1);
    check("abort.busy_before", 32'(busy0), 32'd1);
    rst = 1'b0;
    #1;
    check("abort.busy", 32'(busy0), 32'd0);
    check("abort.rv", 32'(rv0), 32'd0);
    check("abort.err", 32'(err0), 32'd0);
    check("abort.res", 32'(res0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[2], 11, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_otf_converter.md
Name: sd_otf_converter

Overview:
Receiving end of the online adder-tree datapath. Consumes a most-significant-digit-first radix-2 signed-digit stream, encoded as a (p, n) pair, and converts it on the fly into a conventional two's-complement word. The stream comes from the root OA of an adder tree. Uses the Q/QM on-the-fly conversion scheme, so there is no carry-propagate add at the end. It discards the tree's online-delay digits, supports input stalls, and holds the result under an output valid/ready handshake.

Parameters:
N, 16, number of significant digits converted per operand.
DELAY, 2, number of leading valid digits discarded (online delay of upstream tree).
CW, $clog2(N+DELAY+1), digit counter width (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
start  input  1  one-cycle pulse, begins a conversion; honoured only in IDLE.
in_valid  input  1  z_p/z_n carry a digit this cycle.
z_p  input  1  positive rail of the signed digit.
z_n  input  1  negative rail of the signed digit.
out_ready  input  1  downstream accepts the result.
busy  output  1  high from start acceptance until result is accepted.
result  output  N+1  two's-complement integer equal to sum d_j*2^(N-j), j=1..N.
result_valid  output  1  result is stable and valid.
err  output  1  sticky flag: an illegal code p=n=1 was received in this conversion.

Behaviour:
- Reset (rst=0, async): state=IDLE; Q=0; QM=all ones; count=0; result=0; result_valid=0; busy=0; err=0. Asserting rst mid-conversion aborts immediately; no partial result appears.
- Digit decode: (p,n)=(1,0) gives +1; (0,1) gives -1; (0,0) gives 0; (1,1) is treated as 0 and sets err.
- IDLE:
  - start=1 moves to SKIP, or directly to CONV when DELAY=0.
  - On that move: busy=1, err=0, Q=0, QM=all ones, count=0.
  - The digit present in the start cycle is ignored.
  - start is ignored in all other states.
- SKIP:
  - Each in_valid cycle increments count.
  - When DELAY valid digits have been discarded, move to CONV and reset count to 0.
  - Cycles with in_valid=0 change nothing.
- CONV: each in_valid cycle updates Q and QM with a shift-left-and-append of width N+1:
  - d=+1: Q <= {Q,1}; QM <= {Q,0}.
  - d=0: Q <= {Q,0}; QM <= {QM,1}.
  - d=-1: Q <= {QM,1}; QM <= {QM,0}.
  - count increments. On the N-th digit, move to DONE.
  - No sign extension or add is required: Q is exact after N digits. Representable range is -(2^N-1)..+(2^N-1).
- DONE:
  - result=Q and result_valid=1, starting the cycle after the N-th digit is sampled (latency of 1 clock from the last digit).
  - result and result_valid hold while out_ready=0.
  - In a cycle with result_valid=1 and out_ready=1: the handshake completes, next state is IDLE, busy=0, result_valid=0. result keeps its last value until the next DONE.
- Digits arriving in IDLE/DONE (in_valid=1) are dropped.
- Total cycles from start to result_valid with no stalls: DELAY+N+1.
- err remains visible through DONE. It is cleared only by the next accepted start or by reset.

Test Plan:
- N=16, DELAY=0: start, then 16 valid digits of +1 -> result=17'h0FFFF (65535), result_valid at cycle 17 after start, err=0.
- N=16, DELAY=0: 16 digits of -1 -> result=17'h10001 (-65535); digits +1,-1 followed by 14 zeros -> result=17'h04000 (16384).
- N=16, DELAY=2: two leading -1 digits, then +1 followed by 15 zeros -> result=17'h08000 (the leading digits are discarded); result_valid at cycle 19.
- Stalls and backpressure: in_valid toggled 1/0 throughout a conversion -> same result as the unstalled run; out_ready held 0 for 5 cycles -> result and result_valid stable, busy=1; start during DONE ignored.
- Illegal code: one (1,1) digit in CONV with all other digits 0 -> result=0, err=1. err clears on the next accepted start.
- Reset: rst driven low after 8 digits -> all outputs 0 on the same edge. A new conversion after release is unaffected by the aborted one.
